dffram_2p_clr: RTL and testbench
================================

// Module: dffram_2p_clr
// PURPOSE
//   Parametrised two-port (1R/1W) flip-flop RAM: successor to the fixed 128x32 single-port DFFRAM.
//   Adds an independent write port with a byte mask and a registered read port.
//   Adds selectable same-address write-to-read bypass and a built-in sequencer that fills memory with INIT_VAL.
//   Sits beside a CPU or DMA as scratchpad or register-file storage.
// PARAMETERS
//   WORDS     128   number of words; any value >= 2; AWIDTH = $clog2(WORDS) (localparam)
//   WSIZE     4     bytes per word; data width = 8*WSIZE
//   BYPASS    1     1: a same-cycle, same-address read returns the newly written bytes; 0: returns old data
//   INIT_VAL  0     word value written by the clear sequencer (8*WSIZE bits)
// PORTS
//   CLK   in   1        clock; all state changes on the rising edge
//   RST   in   1        reset, synchronous, active-high
//   EN0   in   1        read enable
//   A0    in   AWIDTH   read address
//   Do0   out  8*WSIZE  registered read data
//   WE1   in   WSIZE    write byte mask; bit i writes Di1[8i+7:8i]
//   A1    in   AWIDTH   write address
//   Di1   in   8*WSIZE  write data
//   CLR   in   1        request a full-memory fill with INIT_VAL
//   BUSY  out  1        high while the clear sequencer runs
// BEHAVIOUR
//   Reset (RST=1 at an edge):
//     - Do0=0, BUSY=0, FSM=IDLE, clear counter=0.
//     - Array contents are not reset.
//     - RST has priority over every other input.
//   Read:
//     - EN0=1 at edge N loads Do0 with mem[A0]; the value is visible after edge N (1-cycle latency).
//     - EN0=0: Do0 holds.
//     - A0 >= WORDS: Do0 loads 0.
//   Write:
//     - At an edge with any WE1 bit set, each enabled byte of mem[A1] takes the matching byte of Di1.
//     - Disabled bytes are unchanged.
//     - A1 >= WORDS: the write is ignored.
//   Same edge, EN0=1, A0==A1, WE1!=0:
//     - BYPASS=1: Do0 bytes with WE1 set take Di1; the other bytes take the old mem value.
//     - BYPASS=0: Do0 takes the whole old word.
//   FSM IDLE -> CLEAR: CLR=1 at an edge while in IDLE.
//     - BUSY goes 1 after that edge; the counter starts at 0.
//   FSM CLEAR:
//     - Each edge writes INIT_VAL to mem[counter], then increments the counter.
//     - At counter==WORDS-1: write, return to IDLE, BUSY goes 0 after that edge. Total WORDS cycles.
//     - Port-1 writes are ignored.
//     - CLR is ignored; no restart, no queuing.
//     - Reads stay active and return current contents; words not yet cleared return old data.
//   RST during CLEAR: return to IDLE immediately; memory is left partially cleared.
//   CLR and a port-1 write at the same edge in IDLE: the write completes, then clearing starts next edge.
// TESTING
//   1. WORDS=128, WSIZE=4, RST 2 cycles -> Do0=0, BUSY=0.
//      Write 0xAA0055BB to addr 0x00 with WE1=1111, then read -> Do0=0xAA0055BB one edge after EN0.
//   2. Byte mask: addr 0x12 holds 0xAA0055DD; write 0x00000033 with WE1=0001 -> read 0xAA005533.
//      Write 0x00330000 with WE1=0100 to addr 0x10 (holding 0xAA0055BB) -> read 0xAA3355BB.
//   3. Bypass: addr 0x7F holds 0xF0F055BB; same edge EN0=1, A0=A1=0x7F, WE1=0011, Di1=0x12345678.
//      BYPASS=1 -> Do0=0xF0F05678.
//      BYPASS=0 -> Do0=0xF0F055BB; a following read -> 0xF0F05678.
//   4. Clear: fill all words with 0xDEADBEEF, pulse CLR -> BUSY high for exactly 128 cycles.
//      Every address then reads INIT_VAL.
//      A write to addr 5 during BUSY is dropped (reads INIT_VAL).
//      A second CLR during BUSY does not extend BUSY.
//   5. RST at clear cycle 10: BUSY=0 next edge; addrs 0-9 read INIT_VAL, addr 10 and above keep 0xDEADBEEF.
//   6. Non-power-of-2 WORDS=100: a write to addr 100 is ignored, a read of addr 100 returns 0.
//      Clear takes 100 cycles.

Source files
------------

// File: rtl/dffram_2p_clr.sv
// dffram_2p_clr: parametrised 1R/1W flip-flop RAM with byte-masked writes,
// registered read port, optional same-address write-to-read bypass and a
// built-in sequencer that fills the whole array with INIT_VAL.
//
// Ports:
//   CLK   - clock, all state changes on the rising edge
//   RST   - synchronous active-high reset (Do0, BUSY, FSM, counter; not the array)
//   EN0   - read enable; A0 - read address; Do0 - registered read data
//   WE1   - write byte mask; A1 - write address; Di1 - write data
//   CLR   - request a full-memory fill with INIT_VAL
//   BUSY  - high while the fill sequencer runs
module dffram_2p_clr #(
  parameter int unsigned         WORDS    = 128,
  parameter int unsigned         WSIZE    = 4,
  parameter bit                  BYPASS   = 1'b1,
  parameter logic [8*WSIZE-1:0]  INIT_VAL = '0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       EN0,
  input  logic [$clog2(WORDS)-1:0]   A0,
  output logic [8*WSIZE-1:0]         Do0,
  input  logic [WSIZE-1:0]           WE1,
  input  logic [$clog2(WORDS)-1:0]   A1,
  input  logic [8*WSIZE-1:0]         Di1,
  input  logic                       CLR,
  output logic                       BUSY
);

  localparam int unsigned AWIDTH = $clog2(WORDS);
  localparam int unsigned DW     = 8 * WSIZE;
  // One extra bit so the range check is meaningful when WORDS is a power of 2.
  localparam logic [AWIDTH:0]   WORDS_W = (AWIDTH + 1)'(WORDS);
  localparam logic [AWIDTH-1:0] LAST    = AWIDTH'(WORDS - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic [DW-1:0]       do0_q, do0_d;
  logic [DW-1:0]       mem_q [WORDS];

  logic                clr_wr_c;
  logic                a0_ok_c;
  logic                a1_ok_c;
  logic                p1_we_c;
  logic                wr_en_c;
  logic [AWIDTH-1:0]   wr_addr_c;
  logic [DW-1:0]       wr_data_c;
  logic [WSIZE-1:0]    wr_mask_c;
  logic [DW-1:0]       rd_word_c;

  // State register and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      do0_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      do0_q   <= do0_d;
    end
  end

  // Next-state logic for the fill sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (CLR) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        // CLR is ignored here: no restart and no queued request.
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AWIDTH'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy_d   = (state_d == S_CLEAR);
    clr_wr_c = (state_q == S_CLEAR);
  end

  // Write-port arbitration: the sequencer owns the array while clearing.
  always_comb begin
    a0_ok_c   = ({1'b0, A0} < WORDS_W);
    a1_ok_c   = ({1'b0, A1} < WORDS_W);
    p1_we_c   = !clr_wr_c && a1_ok_c && (|WE1);
    wr_en_c   = 1'b0;
    wr_addr_c = A1;
    wr_data_c = Di1;
    wr_mask_c = WE1;
    if (clr_wr_c) begin
      wr_en_c   = 1'b1;
      wr_addr_c = cnt_q;
      wr_data_c = INIT_VAL;
      wr_mask_c = '1;
    end else if (p1_we_c) begin
      wr_en_c = 1'b1;
    end
    // Reset blocks every array update on its edge, including a fill step.
    if (RST) begin
      wr_en_c = 1'b0;
    end
  end

  // Read path with optional same-address bypass of the port-1 write.
  always_comb begin
    rd_word_c = '0;
    if (a0_ok_c) begin
      rd_word_c = mem_q[A0];
    end
    if (BYPASS && p1_we_c && (A0 == A1)) begin
      for (int unsigned b = 0; b < WSIZE; b++) begin
        if (WE1[b]) begin
          rd_word_c[8*b +: 8] = Di1[8*b +: 8];
        end
      end
    end
    do0_d = EN0 ? rd_word_c : do0_q;
  end

  // Storage array; not reset.
  always_ff @(posedge CLK) begin
    if (wr_en_c) begin
      for (int unsigned b = 0; b < WSIZE; b++) begin
        if (wr_mask_c[b]) begin
          mem_q[wr_addr_c][8*b +: 8] <= wr_data_c[8*b +: 8];
        end
      end
    end
  end

  assign Do0  = do0_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_dffram_2p_clr.sv
module tb_dffram_2p_clr;

  localparam int unsigned AW   = 7;
  localparam logic [31:0] INIT = 32'h5A5A_0F0F;
  localparam logic [31:0] FILL = 32'hDEAD_BEEF;

  logic          CLK = 1'b0;
  logic          RST, EN0, CLR;
  logic [AW-1:0] A0, A1;
  logic [3:0]    WE1;
  logic [31:0]   Di1;

  logic [31:0]   do_a, do_b, do_c;
  logic          busy_a, busy_b, busy_c;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  // a: 128 words, bypass on; b: 128 words, bypass off; c: 100 words, bypass on.
  dffram_2p_clr #(.WORDS(128), .WSIZE(4), .BYPASS(1'b1), .INIT_VAL(INIT)) dut_a (
    .CLK(CLK), .RST(RST), .EN0(EN0), .A0(A0), .Do0(do_a),
    .WE1(WE1), .A1(A1), .Di1(Di1), .CLR(CLR), .BUSY(busy_a));

  dffram_2p_clr #(.WORDS(128), .WSIZE(4), .BYPASS(1'b0), .INIT_VAL(INIT)) dut_b (
    .CLK(CLK), .RST(RST), .EN0(EN0), .A0(A0), .Do0(do_b),
    .WE1(WE1), .A1(A1), .Di1(Di1), .CLR(CLR), .BUSY(busy_b));

  dffram_2p_clr #(.WORDS(100), .WSIZE(4), .BYPASS(1'b1), .INIT_VAL(INIT)) dut_c (
    .CLK(CLK), .RST(RST), .EN0(EN0), .A0(A0), .Do0(do_c),
    .WE1(WE1), .A1(A1), .Di1(Di1), .CLR(CLR), .BUSY(busy_c));

  // Inputs change at the falling edge; outputs are read at the next falling edge.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] mask);
    A1 = addr; Di1 = data; WE1 = mask;
    tick();
    WE1 = 4'h0;
  endtask

  task automatic rd(input logic [AW-1:0] addr);
    A0 = addr; EN0 = 1'b1;
    tick();
    EN0 = 1'b0;
  endtask

  task automatic fill_all(input logic [31:0] data);
    for (int a = 0; a < 128; a++) wr(AW'(a), data, 4'hF);
  endtask

  task automatic test_reset();
    RST = 1'b1; EN0 = 1'b0; CLR = 1'b0; WE1 = 4'h0;
    A0 = '0; A1 = '0; Di1 = '0;
    @(negedge CLK);
    tick(); tick();
    RST = 1'b0;
    tests_run++;
    if (do_a !== 32'h0 || do_b !== 32'h0 || do_c !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_do0 got a=%h b=%h c=%h want 00000000", do_a, do_b, do_c);
    end
    tests_run++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0 || busy_c !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy got a=%b b=%b c=%b want 0", busy_a, busy_b, busy_c);
    end
  endtask

  task automatic test_read_write();
    wr(7'h00, 32'hAA00_55BB, 4'hF);
    tests_run++;
    if (do_a !== 32'h0) begin
      tests_failed++;
      $display("FAIL no_read_before_en got %h want 00000000", do_a);
    end
    rd(7'h00);
    tests_run++;
    if (do_a !== 32'hAA00_55BB || do_c !== 32'hAA00_55BB) begin
      tests_failed++;
      $display("FAIL read_addr0 got a=%h c=%h want aa0055bb", do_a, do_c);
    end
    A0 = 7'h05; EN0 = 1'b0;
    tick();
    tests_run++;
    if (do_a !== 32'hAA00_55BB) begin
      tests_failed++;
      $display("FAIL hold_en0_low got %h want aa0055bb", do_a);
    end
  endtask

  task automatic test_byte_mask();
    wr(7'h12, 32'hAA00_55DD, 4'hF);
    wr(7'h12, 32'h0000_0033, 4'b0001);
    rd(7'h12);
    tests_run++;
    if (do_a !== 32'hAA00_5533) begin
      tests_failed++;
      $display("FAIL mask_byte0 got %h want aa005533", do_a);
    end
    wr(7'h10, 32'hAA00_55BB, 4'hF);
    wr(7'h10, 32'h0033_0000, 4'b0100);
    rd(7'h10);
    tests_run++;
    if (do_a !== 32'hAA33_55BB) begin
      tests_failed++;
      $display("FAIL mask_byte2 got %h want aa3355bb", do_a);
    end
  endtask

  task automatic test_bypass();
    wr(7'h7F, 32'hF0F0_55BB, 4'hF);
    A0 = 7'h7F; EN0 = 1'b1;
    A1 = 7'h7F; WE1 = 4'b0011; Di1 = 32'h1234_5678;
    tick();
    EN0 = 1'b0; WE1 = 4'h0;
    tests_run++;
    if (do_a !== 32'hF0F0_5678) begin
      tests_failed++;
      $display("FAIL bypass_on got %h want f0f05678", do_a);
    end
    tests_run++;
    if (do_b !== 32'hF0F0_55BB) begin
      tests_failed++;
      $display("FAIL bypass_off got %h want f0f055bb", do_b);
    end
    tests_run++;
    if (do_c !== 32'h0) begin
      tests_failed++;
      $display("FAIL bypass_oob got %h want 00000000", do_c);
    end
    rd(7'h7F);
    tests_run++;
    if (do_a !== 32'hF0F0_5678 || do_b !== 32'hF0F0_5678) begin
      tests_failed++;
      $display("FAIL bypass_followup got a=%h b=%h want f0f05678", do_a, do_b);
    end
  endtask

  task automatic test_clear();
    int cnt_a, cnt_c, bad_a, bad_c;
    logic [31:0] exp_c;
    fill_all(FILL);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    cnt_a = 0; cnt_c = 0;
    for (int i = 0; i < 200; i++) begin
      if (busy_a === 1'b1) cnt_a++;
      if (busy_c === 1'b1) cnt_c++;
      if (i == 20) begin A1 = 7'h05; Di1 = 32'h1234_5678; WE1 = 4'hF; end
      if (i == 30) CLR = 1'b1;
      tick();
      WE1 = 4'h0; CLR = 1'b0;
    end
    tests_run++;
    if (cnt_a != 128) begin
      tests_failed++;
      $display("FAIL clear_busy_128 got %0d cycles want 128", cnt_a);
    end
    tests_run++;
    if (cnt_c != 100) begin
      tests_failed++;
      $display("FAIL clear_busy_100 got %0d cycles want 100", cnt_c);
    end
    bad_a = 0; bad_c = 0;
    for (int a = 0; a < 128; a++) begin
      rd(AW'(a));
      exp_c = (a < 100) ? INIT : 32'h0;
      if (do_a !== INIT) bad_a++;
      if (do_c !== exp_c) bad_c++;
    end
    tests_run++;
    if (bad_a != 0) begin
      tests_failed++;
      $display("FAIL clear_readback_128 got %0d bad words want 0", bad_a);
    end
    tests_run++;
    if (bad_c != 0) begin
      tests_failed++;
      $display("FAIL clear_readback_100 got %0d bad words want 0", bad_c);
    end
    rd(7'h05);
    tests_run++;
    if (do_a !== INIT || do_b !== INIT) begin
      tests_failed++;
      $display("FAIL write_dropped_busy got a=%h b=%h want %h", do_a, do_b, INIT);
    end
  endtask

  task automatic test_rst_during_clear();
    int bad_a, bad_c;
    logic [31:0] exp_a, exp_c;
    fill_all(FILL);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tests_run++;
    if (busy_a !== 1'b0 || busy_c !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_clear_busy got a=%b c=%b want 0", busy_a, busy_c);
    end
    bad_a = 0; bad_c = 0;
    for (int a = 0; a < 128; a++) begin
      rd(AW'(a));
      exp_a = (a < 10) ? INIT : FILL;
      exp_c = (a < 10) ? INIT : ((a < 100) ? FILL : 32'h0);
      if (do_a !== exp_a) bad_a++;
      if (do_c !== exp_c) bad_c++;
    end
    tests_run++;
    if (bad_a != 0) begin
      tests_failed++;
      $display("FAIL rst_partial_128 got %0d bad words want 0", bad_a);
    end
    tests_run++;
    if (bad_c != 0) begin
      tests_failed++;
      $display("FAIL rst_partial_100 got %0d bad words want 0", bad_c);
    end
  endtask

  task automatic test_out_of_range();
    wr(7'd100, 32'h1111_1111, 4'hF);
    rd(7'd100);
    tests_run++;
    if (do_c !== 32'h0) begin
      tests_failed++;
      $display("FAIL oob_read_100 got %h want 00000000", do_c);
    end
    tests_run++;
    if (do_a !== 32'h1111_1111) begin
      tests_failed++;
      $display("FAIL inrange_read_100 got %h want 11111111", do_a);
    end
    rd(7'd36);
    tests_run++;
    if (do_c !== FILL) begin
      tests_failed++;
      $display("FAIL oob_no_alias_36 got %h want deadbeef", do_c);
    end
    rd(7'd99);
    tests_run++;
    if (do_c !== FILL) begin
      tests_failed++;
      $display("FAIL oob_no_alias_99 got %h want deadbeef", do_c);
    end
  endtask

  task automatic test_clr_with_write();
    int n;
    A1 = 7'h7F; Di1 = 32'hCAFE_F00D; WE1 = 4'hF; CLR = 1'b1;
    tick();
    WE1 = 4'h0; CLR = 1'b0;
    tests_run++;
    if (busy_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL clr_write_busy got %b want 1", busy_a);
    end
    rd(7'h7F);
    tests_run++;
    if (do_a !== 32'hCAFE_F00D) begin
      tests_failed++;
      $display("FAIL clr_write_completed got %h want cafef00d", do_a);
    end
    n = 0;
    while ((busy_a === 1'b1 || busy_c === 1'b1) && n < 300) begin
      tick();
      n++;
    end
    tests_run++;
    if (busy_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL clr_write_done got busy=%b after %0d cycles want 0", busy_a, n);
    end
    rd(7'h7F);
    tests_run++;
    if (do_a !== INIT) begin
      tests_failed++;
      $display("FAIL clr_write_cleared got %h want %h", do_a, INIT);
    end
  endtask

  initial begin
    test_reset();
    test_read_write();
    test_byte_mask();
    test_bypass();
    test_clear();
    test_rst_during_clear();
    test_out_of_range();
    test_clr_with_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
